mb_stream_unpack: RTL and testbench

MB_STREAM_UNPACK -- requirements
Module: mb_stream_unpack

---
 rtl/mb_pkg.sv | 29 ++
 rtl/mb_word_fifo.sv | 52 +++++
 rtl/mb_stream_unpack.sv | 201 ++++++++++++++++++++
 tb/tb_mb_stream_unpack.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mb_pkg.sv
// Shared constants, component encoding and FSM states for the macroblock
// stream unpacker.
package mb_pkg;

  localparam int unsigned WORDS_PER_MB = 96;
  localparam int unsigned Y_BYTES      = 256;
  localparam int unsigned U_END        = 320;
  localparam int unsigned BYTES_PER_MB = 384;

  typedef enum logic [1:0] {
    COMP_Y = 2'd0,
    COMP_U = 2'd1,
    COMP_V = 2'd2
  } comp_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_DONE
  } state_e;

  function automatic comp_e comp_of(input logic [8:0] b);
    if (b < 9'(Y_BYTES))    return COMP_Y;
    else if (b < 9'(U_END)) return COMP_U;
    else                    return COMP_V;
  endfunction

endpackage

// File: rtl/mb_word_fifo.sv
// Synchronous show-ahead word FIFO with occupancy count; DEPTH must be a
// power of two so the pointers wrap naturally.
module mb_word_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic                       rd_en_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_wr, do_rd;

  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign do_wr     = wr_en_i && !full_o;
  assign do_rd     = rd_en_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_wr) begin
        mem_q[wr_ptr_q] <= wr_data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mb_stream_unpack.sv
// Reads macroblock words from a buffer and serializes them to tagged pixel
// bytes. Define MB_LUMA_SUM_EN to add the per-macroblock luma sum outputs.
module mb_stream_unpack #(
  parameter int unsigned MB_COLS    = 80,
  parameter int unsigned MB_ROWS    = 45,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  output logic [6:0]  r_addr_o,
  output logic        r_ready_o,
  input  logic        r_valid_i,
  input  logic        data_valid_i,
  input  logic [31:0] data_i,
  output logic [7:0]  pix_o,
  output logic        pix_valid_o,
  input  logic        pix_ready_i,
  output logic [1:0]  pix_comp_o,
  output logic        mb_first_o,
  output logic        mb_last_o,
  output logic [6:0]  mb_x_o,
  output logic [5:0]  mb_y_o,
  output logic        frame_done_o,
`ifdef MB_LUMA_SUM_EN
  output logic [15:0] luma_sum_o,
  output logic        luma_sum_valid_o,
`endif
  output logic        overflow_o
);

  import mb_pkg::*;

  localparam int unsigned MB_TOTAL = MB_COLS * MB_ROWS;
  localparam int unsigned MBW      = $clog2(MB_TOTAL + 1);
  localparam int unsigned CW       = $clog2(FIFO_DEPTH) + 1;

  state_e         state_q, state_d;
  logic [6:0]     addr_q;
  logic [MBW-1:0] fmb_q;
  logic           out_q, drop_q, ovf_q;

  logic           fifo_wr, fifo_rd, fifo_full, fifo_empty;
  logic [31:0]    fifo_rdata;
  logic [CW-1:0]  fifo_count;
  logic [CW:0]    inuse;

  logic [31:0]    word_q;
  logic [1:0]     bidx_q;
  logic           sval_q;
  logic [8:0]     b_q;
  logic [6:0]     mbx_q;
  logic [5:0]     mby_q;

  logic           accept, last_addr, last_mb, hs, last_byte, load;

  assign inuse     = {1'b0, fifo_count} + {{CW{1'b0}}, out_q};
  assign accept    = r_ready_o && r_valid_i;
  assign last_addr = (addr_q == 7'(WORDS_PER_MB - 1));
  assign last_mb   = (fmb_q == MBW'(MB_TOTAL - 1));
  assign hs        = sval_q && pix_ready_i;
  assign last_byte = (bidx_q == 2'd3);
  assign load      = !fifo_empty && (!sval_q || (hs && last_byte));
  assign fifo_rd   = load;
  // drop_q covers the first cycle out of reset, when a pre-reset read may still return
  assign fifo_wr   = data_valid_i && !drop_q && !fifo_full;

  mb_word_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (fifo_wr),
    .wr_data_i (data_i),
    .rd_en_i   (fifo_rd),
    .rd_data_o (fifo_rdata),
    .count_o   (fifo_count),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_i) state_d = ST_FETCH;
      ST_FETCH: if (accept && last_addr && last_mb) state_d = ST_DRAIN;
      ST_DRAIN: if (fifo_empty && !sval_q && !out_q) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    r_ready_o    = (state_q == ST_FETCH) && (inuse < (CW+1)'(FIFO_DEPTH));
    frame_done_o = (state_q == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q <= '0;
      fmb_q  <= '0;
      out_q  <= 1'b0;
      drop_q <= 1'b1;
      ovf_q  <= 1'b0;
    end else begin
      drop_q <= 1'b0;
      out_q  <= accept;
      if (data_valid_i && !drop_q && fifo_full) ovf_q <= 1'b1;
      if (accept) begin
        if (last_addr) begin
          addr_q <= '0;
          fmb_q  <= last_mb ? '0 : fmb_q + 1'b1;
        end else begin
          addr_q <= addr_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q <= '0;
      bidx_q <= '0;
      sval_q <= 1'b0;
      b_q    <= '0;
      mbx_q  <= '0;
      mby_q  <= '0;
    end else begin
      if (load) begin
        word_q <= fifo_rdata;
        bidx_q <= '0;
        sval_q <= 1'b1;
      end else if (hs) begin
        if (last_byte) sval_q <= 1'b0;
        else           bidx_q <= bidx_q + 1'b1;
      end
      if (hs) begin
        if (b_q == 9'(BYTES_PER_MB - 1)) begin
          b_q <= '0;
          if (mbx_q == 7'(MB_COLS - 1)) begin
            mbx_q <= '0;
            mby_q <= (mby_q == 6'(MB_ROWS - 1)) ? '0 : mby_q + 1'b1;
          end else begin
            mbx_q <= mbx_q + 1'b1;
          end
        end else begin
          b_q <= b_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    pix_o = '0;
    if (sval_q) begin
      case (bidx_q)
        2'd0:    pix_o = word_q[31:24];
        2'd1:    pix_o = word_q[23:16];
        2'd2:    pix_o = word_q[15:8];
        default: pix_o = word_q[7:0];
      endcase
    end
    pix_valid_o = sval_q;
    pix_comp_o  = sval_q ? comp_of(b_q) : COMP_Y;
    mb_first_o  = sval_q && (b_q == '0);
    mb_last_o   = sval_q && (b_q == 9'(BYTES_PER_MB - 1));
    mb_x_o      = mbx_q;
    mb_y_o      = mby_q;
    r_addr_o    = addr_q;
    overflow_o  = ovf_q;
  end

`ifdef MB_LUMA_SUM_EN
  logic [15:0] lacc_q, lsum_q;
  logic        lval_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lacc_q <= '0;
      lsum_q <= '0;
      lval_q <= 1'b0;
    end else begin
      lval_q <= 1'b0;
      if (hs && (b_q < 9'(Y_BYTES))) begin
        lacc_q <= ((b_q == '0) ? 16'd0 : lacc_q) + {8'd0, pix_o};
        if (b_q == 9'(Y_BYTES - 1)) begin
          lsum_q <= lacc_q + {8'd0, pix_o};
          lval_q <= 1'b1;
        end
      end
    end
  end

  assign luma_sum_o       = lsum_q;
  assign luma_sum_valid_o = lval_q;
`endif

endmodule

// File: tb/tb_mb_stream_unpack.sv
// Scoreboard bench for mb_stream_unpack on a 2x2-macroblock frame.
// Honours MB_LUMA_SUM_EN when it is defined for the build.
module tb_mb_stream_unpack;

  localparam int COLS  = 2;
  localparam int ROWS  = 2;
  localparam int DEPTH = 4;
  localparam int NMB   = COLS * ROWS;

  logic        clk = 1'b0;
  logic        rst_n, start_i, r_ready_o, r_valid_i, data_valid_i;
  logic [6:0]  r_addr_o, mb_x_o;
  logic [5:0]  mb_y_o;
  logic [31:0] data_i;
  logic [7:0]  pix_o;
  logic        pix_valid_o, pix_ready_i, mb_first_o, mb_last_o;
  logic        frame_done_o, overflow_o;
  logic [1:0]  pix_comp_o;
`ifdef MB_LUMA_SUM_EN
  logic [15:0] luma_sum_o;
  logic        luma_sum_valid_o;
  int          luma_acc, luma_exp;
  bit          luma_due;
`endif

  always #5 clk = ~clk;

  mb_stream_unpack #(.MB_COLS(COLS), .MB_ROWS(ROWS), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i),
    .r_addr_o(r_addr_o), .r_ready_o(r_ready_o), .r_valid_i(r_valid_i),
    .data_valid_i(data_valid_i), .data_i(data_i),
    .pix_o(pix_o), .pix_valid_o(pix_valid_o), .pix_ready_i(pix_ready_i),
    .pix_comp_o(pix_comp_o), .mb_first_o(mb_first_o), .mb_last_o(mb_last_o),
    .mb_x_o(mb_x_o), .mb_y_o(mb_y_o), .frame_done_o(frame_done_o),
`ifdef MB_LUMA_SUM_EN
    .luma_sum_o(luma_sum_o), .luma_sum_valid_o(luma_sum_valid_o),
`endif
    .overflow_o(overflow_o)
  );

  typedef struct {
    int          b;
    logic [24:0] tags;  // {pix, comp, first, last, x, y}
  } exp_t;

  typedef struct {
    int         b;
    logic [7:0] pix;
    logic [1:0] comp;
    logic       first;
    logic       last;
  } vec_t;

  typedef struct {
    int ready_mode;
    int rvalid_mode;
    bit data_ff;
  } run_t;

  exp_t sb_q[$];
  int   n_checks = 0, n_fail = 0;

  int   ready_mode = 0, rvalid_mode = 0;
  bit   force_dv = 0, mon_en = 1, data_ff = 0, rec_en = 0, fetching = 0;

  int   cyc = 0, b_addr = 0, b_mb = 0, words_acc = 0, bytes_done = 0;
  int   bytes_in_frame = 0, frame_done_cnt = 0, throttle_cnt = 0;
  int   first_cyc = 0, last_cyc = 0, mb_seen = 0;
  bit   pending = 0, stall_pending = 0;
  logic [31:0] pend_word = '0;
  logic [24:0] stash = '0;
  logic [7:0]  rec_pix [384];
  logic [1:0]  rec_comp [384];
  logic        rec_first [384];
  logic        rec_last [384];
  logic [6:0]  rec_x [NMB];
  logic [5:0]  rec_y [NMB];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [24:0] cur_tags();
    return {pix_o, pix_comp_o, mb_first_o, mb_last_o, mb_x_o, mb_y_o};
  endfunction

  function automatic logic [7:0] byte_of(input int mb, input int i);
    int v;
    if (data_ff) return 8'hFF;
    v = (i + mb * 3) & 255;
    return v[7:0];
  endfunction

  function automatic logic [24:0] model_tags(input int mb, input int i);
    logic [1:0] c;
    int x, y;
    c = (i < 256) ? 2'd0 : (i < 320) ? 2'd1 : 2'd2;
    x = mb % COLS;
    y = mb / COLS;
    return {byte_of(mb, i), c, (i == 0), (i == 383), x[6:0], y[5:0]};
  endfunction

  // Per-cycle driver, buffer responder and output monitor, all at negedge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
`ifdef MB_LUMA_SUM_EN
      if (rst_n && luma_due) begin
        check("luma_valid", {31'd0, luma_sum_valid_o}, 1);
        check("luma_sum", {16'd0, luma_sum_o}, luma_exp);
        if (data_ff) check("luma_sum_ff", {16'd0, luma_sum_o}, 32'hFF00);
        luma_due = 0;
      end
`endif
      if (stall_pending && rst_n) check("stall_hold", {7'd0, cur_tags()}, {7'd0, stash});
      stall_pending = 0;

      data_valid_i = pending | force_dv;
      data_i       = force_dv ? 32'hA5A5_A5A5 : pend_word;
      pending      = 0;
      case (ready_mode)
        0:       pix_ready_i = 1'b1;
        1:       pix_ready_i = (cyc % 3 == 0);
        2:       pix_ready_i = 1'($urandom_range(0, 1));
        default: pix_ready_i = 1'b0;
      endcase
      r_valid_i = (rvalid_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);

      if (!rst_n) begin
        sb_q.delete();
        b_addr = 0; b_mb = 0; fetching = 0; bytes_in_frame = 0;
        words_acc = 0; bytes_done = 0; mb_seen = 0;
`ifdef MB_LUMA_SUM_EN
        luma_acc = 0; luma_due = 0;
`endif
      end else begin
        if (r_ready_o && r_valid_i) begin
          check("r_addr", {25'd0, r_addr_o}, b_addr);
          if (mon_en) check("credit_limit", {31'd0, (words_acc - (bytes_done + 3) / 4) <= DEPTH}, 1);
          pend_word = {byte_of(b_mb, b_addr*4), byte_of(b_mb, b_addr*4+1),
                       byte_of(b_mb, b_addr*4+2), byte_of(b_mb, b_addr*4+3)};
          pending = 1;
          for (int k = 0; k < 4; k++) begin
            exp_t e;
            e.b    = b_addr * 4 + k;
            e.tags = model_tags(b_mb, e.b);
            sb_q.push_back(e);
          end
          words_acc++;
          if (b_addr == 95) begin
            b_addr = 0;
            if (b_mb == NMB - 1) begin b_mb = 0; fetching = 0; end
            else b_mb++;
          end else b_addr++;
        end
        if (fetching && !r_ready_o) throttle_cnt++;

        if (pix_valid_o && pix_ready_i) begin
          if (mon_en) begin
            if (sb_q.size() == 0) check("unexpected_byte", 1, 0);
            else begin
              exp_t e;
              e = sb_q.pop_front();
              check("byte_tags", {7'd0, cur_tags()}, {7'd0, e.tags});
`ifdef MB_LUMA_SUM_EN
              if (e.b < 256) luma_acc += e.tags[24:17];
              if (e.b == 255) begin luma_exp = luma_acc & 16'hFFFF; luma_acc = 0; luma_due = 1; end
`endif
            end
            if (rec_en && bytes_in_frame < 384) begin
              rec_pix[bytes_in_frame]   = pix_o;
              rec_comp[bytes_in_frame]  = pix_comp_o;
              rec_first[bytes_in_frame] = mb_first_o;
              rec_last[bytes_in_frame]  = mb_last_o;
            end
            if (mb_first_o && mb_seen < NMB) begin
              rec_x[mb_seen] = mb_x_o;
              rec_y[mb_seen] = mb_y_o;
              mb_seen++;
            end
            if (bytes_in_frame == 0) first_cyc = cyc;
            bytes_done++;
            bytes_in_frame++;
            if (bytes_in_frame == 1536) last_cyc = cyc;
          end
        end else if (pix_valid_o) begin
          stash = cur_tags();
          stall_pending = 1;
        end

        if (frame_done_o) begin
          frame_done_cnt++;
          if (mon_en) check("done_after_bytes", bytes_in_frame, 1536);
          bytes_in_frame = 0;
          mb_seen = 0;
        end
      end
    end
  end

  task automatic reset_checks(input string tag);
    check({tag, "_ctrl"}, {20'd0, r_addr_o, r_ready_o, pix_valid_o, frame_done_o, overflow_o}, 0);
    check({tag, "_pix"}, {7'd0, cur_tags()}, 0);
`ifdef MB_LUMA_SUM_EN
    check({tag, "_luma"}, {15'd0, luma_sum_valid_o, luma_sum_o}, 0);
`endif
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start_i = 1'b1; fetching = 1;
    @(posedge clk); #1 start_i = 1'b0;
  endtask

  task automatic wait_done(input int prev);
    int t = 0;
    while (frame_done_cnt == prev && t < 20000) begin
      @(posedge clk);
      t++;
    end
    check("frame_done_seen", frame_done_cnt, prev + 1);
    repeat (5) @(posedge clk);
    #1;
    check("frame_done_single", frame_done_cnt, prev + 1);
    check("sb_empty", sb_q.size(), 0);
    check("idle_no_pix", {31'd0, pix_valid_o}, 0);
  endtask

  initial begin
    run_t runs[4];
    vec_t vecs[9];
    logic [6:0] cx [NMB];
    logic [5:0] cy [NMB];
    int prev;

    runs = '{'{0, 0, 1'b0}, '{1, 0, 1'b0}, '{2, 1, 1'b0}, '{0, 0, 1'b1}};
    vecs = '{'{0,   8'h00, 2'd0, 1'b1, 1'b0}, '{1,   8'h01, 2'd0, 1'b0, 1'b0},
             '{2,   8'h02, 2'd0, 1'b0, 1'b0}, '{3,   8'h03, 2'd0, 1'b0, 1'b0},
             '{255, 8'hFF, 2'd0, 1'b0, 1'b0}, '{256, 8'h00, 2'd1, 1'b0, 1'b0},
             '{319, 8'h3F, 2'd1, 1'b0, 1'b0}, '{320, 8'h40, 2'd2, 1'b0, 1'b0},
             '{383, 8'h7F, 2'd2, 1'b0, 1'b1}};
    cx = '{7'd0, 7'd1, 7'd0, 7'd1};
    cy = '{6'd0, 6'd0, 6'd1, 6'd1};

    rst_n = 1'b0; start_i = 1'b0; data_valid_i = 1'b0; data_i = '0;
    r_valid_i = 1'b0; pix_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_checks("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      ready_mode = runs[i].ready_mode;
      rvalid_mode = runs[i].rvalid_mode;
      data_ff = runs[i].data_ff;
      rec_en = (i == 0);
      throttle_cnt = 0;
      prev = frame_done_cnt;
      pulse_start();
      if (i == 1) begin
        repeat (200) @(posedge clk);
        #1 start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
      end
      wait_done(prev);
      if (i == 0) begin
        check("throughput", last_cyc - first_cyc, 1535);
        for (int v = 0; v < 9; v++) begin
          check("vec_pix",   {24'd0, rec_pix[vecs[v].b]},   {24'd0, vecs[v].pix});
          check("vec_comp",  {30'd0, rec_comp[vecs[v].b]},  {30'd0, vecs[v].comp});
          check("vec_first", {31'd0, rec_first[vecs[v].b]}, {31'd0, vecs[v].first});
          check("vec_last",  {31'd0, rec_last[vecs[v].b]},  {31'd0, vecs[v].last});
        end
        for (int m = 0; m < NMB; m++)
          check("mb_coord", {19'd0, rec_x[m], rec_y[m]}, {19'd0, cx[m], cy[m]});
      end
      if (i == 1) check("r_ready_throttle", {31'd0, throttle_cnt > 0}, 1);
    end

    ready_mode = 3; mon_en = 0; data_ff = 0;
    @(posedge clk); #1;
    check("overflow_clear", {31'd0, overflow_o}, 0);
    force_dv = 1;
    repeat (7) @(posedge clk);
    #1 force_dv = 0;
    repeat (2) @(posedge clk);
    #1;
    check("overflow_set", {31'd0, overflow_o}, 1);
    repeat (5) @(posedge clk);
    #1;
    check("overflow_sticky", {31'd0, overflow_o}, 1);

    ready_mode = 0;
    pulse_start();
    repeat (60) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    reset_checks("midframe_reset");
    rst_n = 1'b1; force_dv = 1;
    @(posedge clk); #1 force_dv = 0;
    repeat (4) begin
      @(posedge clk); #1;
      check("drop_after_reset", {31'd0, pix_valid_o}, 0);
    end
    mon_en = 1;

    prev = frame_done_cnt;
    pulse_start();
    wait_done(prev);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
